oled_disp_sched: RTL and testbench

- Display-update scheduler in front of the OLED driver.
- Takes raw binary measurements: frequency, and two duty cycles in 0.1 % units.
- At a fixed refresh rate, snapshots the latest measurement and converts each channel to BCD with a sequential double-dabble.
- Commits all nine digit nibbles to the driver's digit inputs in one cycle, so the OLED never shows a half-updated frame.

---
 rtl/oled_disp_sched.sv | 128 ++++++++++++
 tb/tb_oled_disp_sched.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/oled_disp_sched.sv
// oled_disp_sched: refresh-paced BCD conversion of three measurements, committed atomically to the OLED digits (option: OLED_BLANK_LEAD_EN blanks leading frequency zeros)
module oled_disp_sched #(
  parameter int CLK_HZ     = 12000000,
  parameter int REFRESH_HZ = 4,
  parameter int BIN_W      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             meas_valid,
  input  logic [BIN_W-1:0] freq_bin,
  input  logic [BIN_W-1:0] dc1_bin,
  input  logic [BIN_W-1:0] dc2_bin,
  output logic [3:0]       freq_100,
  output logic [3:0]       freq_10,
  output logic [3:0]       freq_1,
  output logic [3:0]       dc1_10,
  output logic [3:0]       dc1_1,
  output logic [3:0]       dc1_01,
  output logic [3:0]       dc2_10,
  output logic [3:0]       dc2_1,
  output logic [3:0]       dc2_01,
  output logic             upd_done,
  output logic             busy
);
  localparam int PERIOD = CLK_HZ / REFRESH_HZ;
  localparam int RW = PERIOD > 1 ? $clog2(PERIOD) : 1;
  localparam int CW = BIN_W > 1 ? $clog2(BIN_W) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;
  state_t state, nxt;
  logic [RW-1:0] rcnt;
  logic tick, full, last, commit;
  logic [BIN_W-1:0] sh [3];
  logic [BIN_W-1:0] w [2];
  logic [BIN_W-1:0] bin;
  logic [11:0] bcd, adj, bcd_n;
  logic [11:0] res [2];
  logic [CW-1:0] bit_i;
  logic [1:0] ch;
  function automatic logic [3:0] d3(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
  function automatic logic [BIN_W-1:0] sat(input logic [BIN_W-1:0] v);
    return 32'(v) > 32'd999 ? BIN_W'(999) : v;
  endfunction
  assign tick     = rcnt == RW'(PERIOD - 1);
  assign adj      = {d3(bcd[11:8]), d3(bcd[7:4]), d3(bcd[3:0])};
  assign bcd_n    = (adj << 1) | {11'd0, bin[BIN_W-1]};
  assign last     = bit_i == CW'(BIN_W - 1);
  assign commit   = state == SHIFT && last && ch == 2'd2;
  assign busy     = state != IDLE;
  assign upd_done = state == COMMIT;
  // free-running refresh counter, wraps on tick
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rcnt <= '0;
    else rcnt <= tick ? '0 : rcnt + 1'b1;
  // shadow holds the newest saturated measurement until LOAD consumes it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh   <= '{default: '0};
      full <= 1'b0;
    end else if (meas_valid) begin
      sh[0] <= sat(freq_bin);
      sh[1] <= sat(dc1_bin);
      sh[2] <= sat(dc2_bin);
      full  <= 1'b1;
    end else if (state == LOAD) full <= 1'b0;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next-state: a same-cycle capture counts as shadow data for the tick
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = tick && (full || meas_valid) ? LOAD : IDLE;
      LOAD:    nxt = SHIFT;
      SHIFT:   nxt = commit ? COMMIT : SHIFT;
      default: nxt = IDLE;
    endcase
  end
  // double-dabble over the three channels, freq first
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w     <= '{default: '0};
      res   <= '{default: '0};
      bin   <= '0;
      bcd   <= '0;
      bit_i <= '0;
      ch    <= '0;
    end else if (state == LOAD) begin
      w[0]  <= sh[1];
      w[1]  <= sh[2];
      bin   <= sh[0];
      bcd   <= '0;
      bit_i <= '0;
      ch    <= '0;
    end else if (state == SHIFT) begin
      if (last) begin
        if (ch != 2'd2) res[ch[0]] <= bcd_n;
        bin   <= ch == 2'd0 ? w[0] : w[1];
        bcd   <= '0;
        bit_i <= '0;
        ch    <= ch + 1'b1;
      end else begin
        bcd   <= bcd_n;
        bin   <= bin << 1;
        bit_i <= bit_i + 1'b1;
      end
    end
  // all nine digits land on the edge entering COMMIT
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {freq_100, freq_10, freq_1} <= '0;
      {dc1_10, dc1_1, dc1_01}     <= '0;
      {dc2_10, dc2_1, dc2_01}     <= '0;
    end else if (commit) begin
`ifdef OLED_BLANK_LEAD_EN
      freq_100 <= res[0][11:8] == 4'd0 ? 4'hF : res[0][11:8];
      freq_10  <= res[0][11:4] == 8'd0 ? 4'hF : res[0][7:4];
`else
      freq_100 <= res[0][11:8];
      freq_10  <= res[0][7:4];
`endif
      freq_1 <= res[0][3:0];
      {dc1_10, dc1_1, dc1_01} <= res[1];
      {dc2_10, dc2_1, dc2_01} <= bcd_n;
    end
endmodule

// File: tb/tb_oled_disp_sched.sv
// tb_oled_disp_sched: two instances (100- and 20-cycle refresh) checked every cycle against an arithmetic model
module tb_oled_disp_sched;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] mv;
  logic [1:0][9:0] fb, d1, d2;
  wire  [1:0][35:0] dg;
  wire  [1:0] ud, bz;
  int checks = 0, errors = 0;
  int cnt [2], rem [2], nd [2];
  int sv [2][3], snap [2][3];
  bit full [2];
  bit tk, st;
  logic [35:0] edig [2];
  always #5 clk = ~clk;
  oled_disp_sched #(.CLK_HZ(100), .REFRESH_HZ(1), .BIN_W(10)) u_a (
    .clk(clk), .rst_n(rst_n), .meas_valid(mv[0]), .freq_bin(fb[0]), .dc1_bin(d1[0]), .dc2_bin(d2[0]),
    .freq_100(dg[0][35:32]), .freq_10(dg[0][31:28]), .freq_1(dg[0][27:24]),
    .dc1_10(dg[0][23:20]), .dc1_1(dg[0][19:16]), .dc1_01(dg[0][15:12]),
    .dc2_10(dg[0][11:8]), .dc2_1(dg[0][7:4]), .dc2_01(dg[0][3:0]),
    .upd_done(ud[0]), .busy(bz[0]));
  oled_disp_sched #(.CLK_HZ(20), .REFRESH_HZ(1), .BIN_W(10)) u_b (
    .clk(clk), .rst_n(rst_n), .meas_valid(mv[1]), .freq_bin(fb[1]), .dc1_bin(d1[1]), .dc2_bin(d2[1]),
    .freq_100(dg[1][35:32]), .freq_10(dg[1][31:28]), .freq_1(dg[1][27:24]),
    .dc1_10(dg[1][23:20]), .dc1_1(dg[1][19:16]), .dc1_01(dg[1][15:12]),
    .dc2_10(dg[1][11:8]), .dc2_1(dg[1][7:4]), .dc2_01(dg[1][3:0]),
    .upd_done(ud[1]), .busy(bz[1]));
  function automatic int per(input int k);
    return k == 0 ? 100 : 20;
  endfunction
  function automatic int sat(input int v);
    return v > 999 ? 999 : v;
  endfunction
  function automatic logic [11:0] ddig(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  function automatic logic [11:0] fdig(input int v);
    logic [11:0] r;
    r = ddig(v);
`ifdef OLED_BLANK_LEAD_EN
    if (v < 100) r[11:8] = 4'hF;
    if (v < 10) r[7:4] = 4'hF;
`endif
    return r;
  endfunction
  // model: an update occupies 32 cycles after the accepting tick; the last is the commit
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        cnt[k] = 0; rem[k] = 0; full[k] = 0; edig[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        tk = cnt[k] == per(k) - 1;
        cnt[k] = (cnt[k] + 1) % per(k);
        if (rem[k] == 32) snap[k] = sv[k];
        st = rem[k] == 0 && tk && (full[k] || mv[k]);
        if (mv[k]) begin
          sv[k][0] = sat(int'(fb[k])); sv[k][1] = sat(int'(d1[k])); sv[k][2] = sat(int'(d2[k]));
          full[k] = 1;
        end else if (rem[k] == 32) full[k] = 0;
        rem[k] = st ? 32 : (rem[k] > 0 ? rem[k] - 1 : 0);
        if (rem[k] == 1) edig[k] = {fdig(snap[k][0]), ddig(snap[k][1]), ddig(snap[k][2])};
      end
    end
  // per-cycle comparison of both instances against the model
  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dg[k] !== edig[k] || ud[k] !== (rem[k] == 1) || bz[k] !== (rem[k] > 0)) begin
        errors++;
        $display("FAIL model dut%0d t=%0t digits=%h exp=%h done=%b exp=%b busy=%b exp=%b",
                 k, $time, dg[k], edig[k], ud[k], rem[k] == 1, bz[k], rem[k] > 0);
      end
    end
  always @(negedge clk)
    if (rst_n) for (int k = 0; k < 2; k++) nd[k] += int'(ud[k]);
  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic meas(input int k, input int f, input int a, input int b);
    @(negedge clk);
    mv[k] = 1'b1; fb[k] = 10'(f); d1[k] = 10'(a); d2[k] = 10'(b);
    @(negedge clk);
    mv[k] = 1'b0;
  endtask
  task automatic wait_busy(input int k, input int lim);
    bit ok;
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      ok = bz[k];
    end
    chk($sformatf("busy_timeout_dut%0d", k), longint'(ok), 1);
  endtask
  task automatic wait_done(input int k, input int lim, output int n);
    bit ok;
    ok = 0; n = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      ok = ud[k];
      n = i + 1;
    end
    chk($sformatf("done_timeout_dut%0d", k), longint'(ok), 1);
  endtask
  initial begin
    int n, base;
    mv = '0; fb = '0; d1 = '0; d2 = '0; nd = '{0, 0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    chk("nodata_done_a", nd[0], 0);
    chk("nodata_done_b", nd[1], 0);
    chk("nodata_digits_a", dg[0], 0);
    base = nd[1];
    meas(1, 500, 250, 999);
    wait_busy(1, 40);
    repeat (5) @(negedge clk);
    meas(1, 100, 0, 5);
    wait_done(1, 60, n);
    chk("drop_first_commit", dg[1], 36'h500_250_999);
    wait_done(1, 60, n);
    chk("drop_second_commit", dg[1], 36'h100_000_005);
    repeat (60) @(negedge clk);
    chk("drop_done_count", nd[1] - base, 2);
    meas(0, 523, 487, 12);
    wait_busy(0, 150);
    wait_done(0, 40, n);
    chk("basic_latency", n, 31);
    chk("basic_digits", dg[0], 36'h523_487_012);
    meas(0, 1023, 0, 999);
    wait_done(0, 150, n);
    chk("sat_digits", dg[0], 36'h999_000_999);
    meas(0, 7, 5, 1000);
    wait_done(0, 150, n);
`ifdef OLED_BLANK_LEAD_EN
    chk("blank_7", dg[0], 36'hFF7_005_999);
`else
    chk("blank_7", dg[0], 36'h007_005_999);
`endif
    meas(0, 40, 999, 100);
    wait_done(0, 150, n);
`ifdef OLED_BLANK_LEAD_EN
    chk("blank_40", dg[0], 36'hF40_999_100);
`else
    chk("blank_40", dg[0], 36'h040_999_100);
`endif
    meas(0, 321, 1, 2);
    wait_busy(0, 150);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_digits_a", dg[0], 0);
    chk("reset_digits_b", dg[1], 0);
    chk("reset_flags_a", {bz[0], ud[0]}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = nd[0];
    repeat (250) @(negedge clk);
    chk("reset_no_commit", nd[0] - base, 0);
    chk("reset_hold_digits", dg[0], 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
